// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
//
// Holds the handshake-stage state encoding and default widths used by
// pipe_stage_skid and its sub-modules. The stage never stores this state
// explicitly; it is derived from the two valid bits so that debug logic and
// assertions can refer to it by name.

package pipeline_pkg;

  // state        | meaning
  // ST_EMPTY     | no entry held, in_ready_o=1
  // ST_BUSY      | main entry held, skid empty
  // ST_FULL      | main and skid entries held, upstream blocked
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int STAGE_CNT_W_DEFAULT = 32;

  function automatic stage_state_e stage_state(input logic mvalid, input logic svalid);
    if (svalid)      return ST_FULL;
    else if (mvalid) return ST_BUSY;
    else             return ST_EMPTY;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//
// Ports:
//   clk_i  in   clock, rising edge
//   rst    in   synchronous, active-high reset (clears the count)
//   inc_i  in   count this cycle
//   cnt_o  out  current count, holds at all-ones instead of wrapping

module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic at_max;

  assign at_max = (cnt_o == {W{1'b1}});

  always_ff @(posedge clk_i) begin
    if (rst) begin
      cnt_o <= '0;
    end else if (inc_i && !at_max) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Reusable pipeline stage register with valid/ready handshake.
//
// A main register drives the downstream side directly. With SKID=1 a second
// register catches the payload accepted in the cycle the downstream stalls,
// which lets in_ready_o come straight from a flop (no path from out_ready_i)
// while still sustaining one payload per cycle. With SKID=0 the stage holds a
// single entry and in_ready_o is combinational.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst          in   synchronous, active-high reset; clears all entries
//   flush_i      in   squash all held entries next cycle
//   in_valid_i   in   upstream payload valid
//   in_ready_o   out  stage accepts a payload this cycle
//   in_data_i    in   upstream payload
//   out_valid_o  out  downstream payload valid
//   out_ready_i  in   downstream accepts this cycle
//   out_data_o   out  downstream payload
//   stall_cnt_o  out  saturating count of cycles with valid output not taken

module pipe_stage_skid
  import pipeline_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter bit SKID       = 1'b1,
  parameter bit FLUSH_ZERO = 1'b1,
  parameter int CNT_W      = STAGE_CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic             mvalid, mvalid_n;
  logic             svalid, svalid_n;
  logic [WIDTH-1:0] mdata, mdata_n;
  logic [WIDTH-1:0] sdata, sdata_n;
  logic             acc, ret;
  stage_state_e     state;

  assign state = stage_state(mvalid, svalid);

  // Skid mode: ready depends only on the registered skid valid, so the
  // upstream never sees a path from out_ready_i.
  assign in_ready_o  = SKID ? !svalid : (!mvalid || out_ready_i);
  assign acc         = in_valid_i && in_ready_o;
  assign ret         = mvalid && out_ready_i;
  assign out_valid_o = mvalid;
  assign out_data_o  = mdata;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      mvalid <= 1'b0;
      svalid <= 1'b0;
      mdata  <= '0;
      sdata  <= '0;
    end else begin
      mvalid <= mvalid_n;
      svalid <= svalid_n;
      mdata  <= mdata_n;
      sdata  <= sdata_n;
    end
  end

  always_comb begin
    mvalid_n = mvalid;
    svalid_n = svalid;
    mdata_n  = mdata;
    sdata_n  = sdata;

    if (flush_i) begin
      // A payload accepted alongside the flush is dropped with the rest.
      mvalid_n = 1'b0;
      svalid_n = 1'b0;
      if (FLUSH_ZERO) begin
        mdata_n = '0;
        sdata_n = '0;
      end
    end else if (SKID) begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            mvalid_n = 1'b1;
            mdata_n  = in_data_i;
          end
        end
        ST_BUSY: begin
          if (acc && ret) begin
            mdata_n = in_data_i;
          end else if (acc) begin
            svalid_n = 1'b1;
            sdata_n  = in_data_i;
          end else if (ret) begin
            mvalid_n = 1'b0;
          end
        end
        ST_FULL: begin
          // Skid entry is older than anything upstream, so it moves up
          // before new data may be accepted.
          if (ret) begin
            mdata_n  = sdata;
            svalid_n = 1'b0;
          end
        end
        default: begin
          mvalid_n = 1'b0;
          svalid_n = 1'b0;
        end
      endcase
    end else begin
      if (acc) begin
        mvalid_n = 1'b1;
        mdata_n  = in_data_i;
      end else if (ret) begin
        mvalid_n = 1'b0;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst   (rst),
    .inc_i (mvalid && !out_ready_i),
    .cnt_o (stall_cnt_o)
  );

`ifndef SYNTHESIS
  a_skid_needs_main : assert property (@(posedge clk_i) disable iff (rst)
    svalid |-> mvalid);

  a_stall_stable : assert property (@(posedge clk_i) disable iff (rst)
    (out_valid_o && !out_ready_i && !flush_i) |=> $stable(out_data_o));

  a_full_not_ready : assert property (@(posedge clk_i) disable iff (rst)
    (state == ST_FULL) |-> !in_ready_o);
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid instance (A), a single-entry
// instance (B) and a 4-bit stall-counter instance (C) share clock and reset.

module tb_pipe_stage_skid;

  logic clk_i = 1'b0;
  logic rst;

  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data, a_stall;
  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data, b_stall;
  logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_in_data, c_out_data;
  logic [3:0] c_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_skid #(.WIDTH(8), .SKID(1'b1), .FLUSH_ZERO(1'b1), .CNT_W(8)) u_a (
    .clk_i(clk_i), .rst(rst), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .stall_cnt_o(a_stall));

  pipe_stage_skid #(.WIDTH(8), .SKID(1'b0), .FLUSH_ZERO(1'b1), .CNT_W(8)) u_b (
    .clk_i(clk_i), .rst(rst), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .stall_cnt_o(b_stall));

  pipe_stage_skid #(.WIDTH(8), .SKID(1'b1), .FLUSH_ZERO(1'b1), .CNT_W(4)) u_c (
    .clk_i(clk_i), .rst(rst), .flush_i(c_flush),
    .in_valid_i(c_in_valid), .in_ready_o(c_in_ready), .in_data_i(c_in_data),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data),
    .stall_cnt_o(c_stall));

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_in_valid = 1; a_in_data = 8'hAA; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_data = 8'h00; b_out_ready = 1;
    c_flush = 0; c_in_valid = 0; c_in_data = 8'h00; c_out_ready = 1;

    // 1: reset with a payload offered
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out_valid", 32'(a_out_valid), 32'h0);
      chk("rst_out_data",  32'(a_out_data),  32'h0);
      chk("rst_in_ready",  32'(a_in_ready),  32'h1);
      chk("rst_stall",     32'(a_stall),     32'h0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(a_out_valid), 32'h1);
    chk("post_rst_data",  32'(a_out_data),  32'hAA);
    a_in_valid = 0;
    tick();
    chk("post_rst_drain", 32'(a_out_valid), 32'h0);

    // 2: back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = 8'(i);
      tick();
      chk("stream_valid", 32'(a_out_valid), 32'h1);
      chk("stream_data",  32'(a_out_data),  32'(i));
      chk("stream_ready", 32'(a_in_ready),  32'h1);
    end
    a_in_valid = 0;
    tick();
    chk("stream_end_valid", 32'(a_out_valid), 32'h0);
    chk("stream_stall",     32'(a_stall),     32'h0);

    // 3: back-pressure into the skid register
    a_in_valid = 1; a_in_data = 8'h10; a_out_ready = 1;
    tick();
    chk("bp_load", 32'(a_out_data), 32'h10);
    a_out_ready = 0; a_in_data = 8'h11;
    tick();
    chk("bp_hold_data",  32'(a_out_data),  32'h10);
    chk("bp_hold_valid", 32'(a_out_valid), 32'h1);
    chk("bp_full_ready", 32'(a_in_ready),  32'h0);
    a_in_data = 8'h12;
    tick();
    chk("bp_hold_data2", 32'(a_out_data), 32'h10);
    chk("bp_full_ready2", 32'(a_in_ready), 32'h0);
    tick();
    chk("bp_stall_cnt", 32'(a_stall), 32'h3);
    a_out_ready = 1;
    tick();
    chk("bp_order_11", 32'(a_out_data), 32'h11);
    chk("bp_ready_back", 32'(a_in_ready), 32'h1);
    tick();
    chk("bp_order_12", 32'(a_out_data), 32'h12);
    chk("bp_valid_12", 32'(a_out_valid), 32'h1);
    a_in_valid = 0;
    tick();
    chk("bp_drained", 32'(a_out_valid), 32'h0);
    chk("bp_stall_kept", 32'(a_stall), 32'h3);

    // 4: flush while FULL, with a payload offered in the flush cycle
    a_in_valid = 1; a_in_data = 8'h20; a_out_ready = 1;
    tick();
    a_out_ready = 0; a_in_data = 8'h21;
    tick();
    chk("fl_full_ready", 32'(a_in_ready), 32'h0);
    a_flush = 1; a_in_data = 8'h55;
    tick();
    chk("fl_valid", 32'(a_out_valid), 32'h0);
    chk("fl_data",  32'(a_out_data),  32'h0);
    chk("fl_ready", 32'(a_in_ready),  32'h1);
    chk("fl_stall_kept", 32'(a_stall), 32'h5);
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_55", 32'(a_out_valid), 32'h0);
    end

    // 5: single-entry stage, combinational ready
    b_in_valid = 1; b_in_data = 8'h33; b_out_ready = 0;
    tick();
    chk("b_load", 32'(b_out_data), 32'h33);
    b_in_data = 8'h77;
    #1;
    chk("b_busy_ready", 32'(b_in_ready), 32'h0);
    tick();
    chk("b_hold", 32'(b_out_data), 32'h33);
    b_out_ready = 1;
    #1;
    chk("b_comb_ready", 32'(b_in_ready), 32'h1);
    tick();
    chk("b_new_data",  32'(b_out_data),  32'h77);
    chk("b_new_valid", 32'(b_out_valid), 32'h1);
    b_in_valid = 0;
    tick();
    chk("b_drained", 32'(b_out_valid), 32'h0);
    chk("b_stall",   32'(b_stall),     32'h1);

    // 6: 4-bit stall counter saturation
    c_in_valid = 1; c_in_data = 8'h05; c_out_ready = 0;
    tick();
    c_in_valid = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("c_at_15", 32'(c_stall), 32'hF);
    for (int i = 0; i < 5; i++) tick();
    chk("c_sat", 32'(c_stall), 32'hF);
    c_flush = 1;
    tick();
    c_flush = 0;
    tick();
    chk("c_flush_keeps", 32'(c_stall), 32'hF);
    chk("c_flushed", 32'(c_out_valid), 32'h0);
    rst = 1;
    tick();
    rst = 0;
    chk("c_rst_clears", 32'(c_stall), 32'h0);
    chk("a_rst_clears", 32'(a_stall), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional skid buffer.
- Generalises the fixed, always-advancing inter-stage registers into a single reusable stage.
- Supports back-pressure, bubble squash on branch/exception flush, and full throughput with a registered ready path.
- Sits between any two core stages (IF/ID … MEM1/MEM2/WB). The payload is the packed stage struct, sized with $bits.

Parameters:
- WIDTH, 64: payload width in bits. Instantiated as $bits(<stage>_Pipe_t).
- SKID, 1: 1 = two-entry skid stage with registered in_ready_o. 0 = single-entry stage with combinational in_ready_o.
- FLUSH_ZERO, 1: 1 = flush also zeroes stored payloads. 0 = flush clears valid bits only.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous squash of all held entries
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  stage can accept a payload this cycle
- in_data_i  in  WIDTH  upstream payload
- out_valid_o  out  1  downstream payload valid
- out_ready_i  in  1  downstream accepts this cycle
- out_data_o  out  WIDTH  downstream payload
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating

Behaviour:
- Definitions:
  - acc = in_valid_i & in_ready_o
  - ret = out_valid_o & out_ready_i
- Storage:
  - Main register (mvalid, mdata) drives out_valid_o / out_data_o directly.
  - Skid register (svalid, sdata) exists only when SKID=1.
- Reset values: mvalid=svalid=0, mdata=sdata=0, stall_cnt_o=0.
  - Hence out_valid_o=0, out_data_o=0, in_ready_o=1.
- Latency: exactly 1 cycle from acc to out_valid_o=1 (stage empty or draining). Throughput is 1 payload/cycle in both modes.
- SKID=1:
  - in_ready_o = !svalid (registered, no combinational path from out_ready_i).
  - EMPTY (mvalid=0, svalid=0): acc → BUSY, main<=in.
  - BUSY (mvalid=1, svalid=0):
    - acc&ret → BUSY, main<=in.
    - acc&!ret → FULL, skid<=in.
    - !acc&ret → EMPTY.
    - otherwise hold.
  - FULL (mvalid=1, svalid=1): in_ready_o=0.
    - ret → BUSY, main<=skid, svalid<=0.
    - otherwise hold.
- SKID=0:
  - in_ready_o = !mvalid | out_ready_i.
  - Only EMPTY and BUSY exist.
  - acc → main<=in.
  - ret&!acc → EMPTY.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o holds constant.
- Flush:
  - flush_i=1 → next cycle mvalid=svalid=0. If FLUSH_ZERO=1, mdata=sdata=0.
  - A payload offered with acc in the same cycle as flush is dropped.
  - ret in the flush cycle still counts as delivered; downstream sees it.
- Priority: rst > flush_i > handshake.
  - rst mid-transfer discards all entries and zeroes the payload regardless of FLUSH_ZERO.
- Stall counter:
  - Increments when out_valid_o & !out_ready_i.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by rst; flush does not clear it.
- Upstream protocol violations (in_data_i changing while in_valid_i & !in_ready_o) need no detection; the stage samples on acc only.

Decomposition:
- pipeline_pkg gains:
  - typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} stage_state_e. Used for debug/assertions; state is derived from mvalid/svalid.
  - localparam STAGE_CNT_W_DEFAULT = 32.
- Sub-module sat_counter #(W) (clk_i, rst, inc_i, cnt_o): saturating up-counter, reusable for other perf counters.
- SVA in the same file, guarded by ifndef SYNTHESIS:
  - no svalid without mvalid
  - out_data_o stable under stall
  - in_ready_o=0 in FULL

Test Plan:
1. rst=1 for 2 cycles with in_valid_i=1, in_data_i=0xAA → out_valid_o=0, out_data_o=0, in_ready_o=1, stall_cnt_o=0 throughout; after release, 0xAA appears 1 cycle later.
2. SKID=1 streaming: 8 payloads 0x1..0x8 back-to-back, out_ready_i=1 → outputs 0x1..0x8 on consecutive cycles, in_ready_o constantly 1.
3. SKID=1 back-pressure: stream 0x10,0x11,0x12 with out_ready_i=0 from cycle 1 → 0x10 held on output, 0x11 in skid, in_ready_o=0, 0x12 not accepted. Raise out_ready_i → sequence 0x10,0x11,0x12 in order. stall_cnt_o equals stalled cycle count.
4. Flush while FULL (FLUSH_ZERO=1), in_valid_i=1 with 0x55 → next cycle out_valid_o=0, out_data_o=0, in_ready_o=1; 0x55 never emerges.
5. SKID=0, out_ready_i=0, stage BUSY → in_ready_o=0. Raise out_ready_i with in_valid_i=1, data 0x77 → same-cycle accept; next cycle out_data_o=0x77.
6. CNT_W=4, stall 20 cycles → stall_cnt_o saturates at 15; a flush leaves it at 15; rst returns it to 0.
